// File: rtl/vending_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vending_pkg
//  Description : Shared types for the vending-machine coin path: the coin
//                kind carried through the acceptor queue and the encoding of
//                the acceptor's pulse-emit state machine.
//  Revision    : 1.0 - initial release
// ============================================================================
package vending_pkg;

  typedef enum logic {
    COIN_NICKEL = 1'b0,
    COIN_DIME   = 1'b1
  } coin_t;

  typedef enum logic [1:0] {
    EMIT_IDLE  = 2'd0,
    EMIT_PULSE = 2'd1,
    EMIT_GAP   = 2'd2
  } emit_state_t;

endpackage
`default_nettype wire

// File: rtl/coin_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : coin_debounce
//  Description : Two-flop synchroniser plus counter debouncer for one coin
//                slot sensor. Raises o_rise for one cycle, combinationally,
//                in the cycle whose closing edge flips the accepted level
//                from 0 to 1.
//  Ports       : clk      - clock
//                rst      - synchronous active-high reset
//                i_raw    - asynchronous sensor level
//                o_rise   - coin event (accepted 0->1 transition)
//  Revision    : 1.0 - initial release
// ============================================================================
module coin_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_rise
);

  // Counter needs to reach DEBOUNCE_CYCLES-1; keep at least one bit so the
  // DEBOUNCE_CYCLES==1 case still elaborates.
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_s1;
  logic             r_s2;
  logic             r_stable;
  logic [CNT_W-1:0] r_cnt;
  logic             w_toggle;

  // The accepted level flips on the edge where the synced level has
  // disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
  assign w_toggle = (r_s2 != r_stable) && (r_cnt == c_cnt_max);
  assign o_rise   = w_toggle && !r_stable;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1     <= 1'b0;
      r_s2     <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_s1 <= i_raw;
      r_s2 <= r_s1;
      if (r_s2 == r_stable) begin
        r_cnt <= '0;
      end else if (w_toggle) begin
        r_stable <= ~r_stable;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/coin_acceptor.sv
`default_nettype none
// ============================================================================
//  Module      : coin_acceptor
//  Description : Vending-machine input stage. Debounces the nickel and dime
//                sensors, queues accepted coins and replays them as spaced,
//                mutually exclusive single-cycle N/D pulses.
//  Ports       : clk        - clock
//                rst        - synchronous active-high reset
//                nickel_raw - asynchronous nickel sensor level
//                dime_raw   - asynchronous dime sensor level
//                hold       - stall: no coin is popped while high (IDLE only)
//                N, D       - one-cycle coin pulses (registered)
//                pending    - queue occupancy (registered)
//                overflow   - sticky flag, set when an accepted coin is lost
//  Revision    : 1.0 - initial release
// ============================================================================
module coin_acceptor
  import vending_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            nickel_raw,
  input  logic                            dime_raw,
  input  logic                            hold,
  output logic                            N,
  output logic                            D,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] pending,
  output logic                            overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  // ---------------------------------------------------------------- debounce
  logic w_n_ev;
  logic w_d_ev;

  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbnc_nickel (
    .clk    (clk),
    .rst    (rst),
    .i_raw  (nickel_raw),
    .o_rise (w_n_ev)
  );

  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbnc_dime (
    .clk    (clk),
    .rst    (rst),
    .i_raw  (dime_raw),
    .o_rise (w_d_ev)
  );

  // -------------------------------------------------------------------- FIFO
  coin_t            r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_overflow;

  logic [CNT_W-1:0] w_free;
  logic [PTR_W-1:0] w_wr_ptr_p1;
  logic             w_wr0_en;
  coin_t            w_wr0_val;
  logic             w_wr1_en;
  logic [1:0]       w_nwr;
  logic             w_drop;
  logic             w_pop;
  coin_t            w_head;

  // Space is judged on the occupancy at the start of the cycle, so a pop in
  // the same cycle never makes room for an arriving coin.
  assign w_free      = CNT_W'(FIFO_DEPTH) - r_count;
  assign w_wr_ptr_p1 = r_wr_ptr + PTR_W'(1);
  assign w_head      = r_mem[r_rd_ptr];

  // Write slot 0 takes the nickel when both lines fire; the dime goes to
  // slot 1 only if two entries are free.
  always_comb begin
    w_wr0_en  = 1'b0;
    w_wr0_val = COIN_NICKEL;
    w_wr1_en  = 1'b0;
    w_nwr     = 2'd0;
    w_drop    = 1'b0;
    if (w_n_ev && w_d_ev) begin
      if (w_free >= CNT_W'(2)) begin
        w_wr0_en = 1'b1;
        w_wr1_en = 1'b1;
        w_nwr    = 2'd2;
      end else if (w_free == CNT_W'(1)) begin
        w_wr0_en = 1'b1;
        w_nwr    = 2'd1;
        w_drop   = 1'b1;
      end else begin
        w_drop   = 1'b1;
      end
    end else if (w_n_ev || w_d_ev) begin
      if (w_free != '0) begin
        w_wr0_en  = 1'b1;
        w_wr0_val = w_n_ev ? COIN_NICKEL : COIN_DIME;
        w_nwr     = 2'd1;
      end else begin
        w_drop    = 1'b1;
      end
    end
  end

  // Storage carries no reset: an entry is only read after it was written.
  always_ff @(posedge clk) begin
    if (w_wr0_en) r_mem[r_wr_ptr]    <= w_wr0_val;
    if (w_wr1_en) r_mem[w_wr_ptr_p1] <= COIN_DIME;
  end

  // Depth is a power of two, so pointer wrap is plain truncation.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_wr_ptr   <= r_wr_ptr + PTR_W'(w_nwr);
      r_rd_ptr   <= r_rd_ptr + PTR_W'(w_pop);
      r_count    <= r_count + CNT_W'(w_nwr) - CNT_W'(w_pop);
      r_overflow <= r_overflow | w_drop;
    end
  end

  // ---------------------------------------------------------------- emit FSM
  emit_state_t r_state;
  emit_state_t w_state_nxt;
  logic        r_n;
  logic        r_d;
  logic        w_n_nxt;
  logic        w_d_nxt;

  // The pulse value is decided at pop time and registered, so N/D come
  // straight from flops during PULSE. GAP plus the IDLE decision cycle give
  // the three-cycle spacing the downstream FSM relies on.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_n_nxt     = 1'b0;
    w_d_nxt     = 1'b0;
    case (r_state)
      EMIT_IDLE: begin
        if ((r_count != '0) && !hold) begin
          w_pop       = 1'b1;
          w_n_nxt     = (w_head == COIN_NICKEL);
          w_d_nxt     = (w_head == COIN_DIME);
          w_state_nxt = EMIT_PULSE;
        end
      end
      EMIT_PULSE: w_state_nxt = EMIT_GAP;
      EMIT_GAP:   w_state_nxt = EMIT_IDLE;
      default:    w_state_nxt = EMIT_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= EMIT_IDLE;
      r_n     <= 1'b0;
      r_d     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_n     <= w_n_nxt;
      r_d     <= w_d_nxt;
    end
  end

  assign N        = r_n;
  assign D        = r_d;
  assign pending  = r_count;
  assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_coin_acceptor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_coin_acceptor
//  Description : Self-checking bench for coin_acceptor: cycle-by-cycle
//                comparison against a reference model, a vector table for
//                the single-nickel case, directed corner sequences and a
//                randomized sensor/hold/reset phase.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_coin_acceptor;
  import vending_pkg::*;

  localparam int DB    = 4;
  localparam int DEPTH = 4;
  localparam int PW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          nickel_raw = 1'b0;
  logic          dime_raw = 1'b0;
  logic          hold = 1'b0;
  logic          N;
  logic          D;
  logic [PW-1:0] pending;
  logic          overflow;

  coin_acceptor #(.DEBOUNCE_CYCLES(DB), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .nickel_raw (nickel_raw),
    .dime_raw   (dime_raw),
    .hold       (hold),
    .N          (N),
    .D          (D),
    .pending    (pending),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // ------------------------------------------------------- reference model
  // Sensor path: a line is accepted once its twice-delayed sample has sat
  // at the opposite level for the last DB cycles. Queue is an SV queue;
  // the emitter is a "cycles until next pop allowed" countdown.
  bit    m_s1   [2];
  bit    m_s2   [2];
  bit    m_hist [2][DB];
  bit    m_acc  [2];
  coin_t m_q[$];
  bit    m_ovf;
  bit    m_n;
  bit    m_d;
  int    m_block;

  function automatic void model_step(bit r, bit rn, bit rd, bit h);
    bit    raw [2];
    bit    ev  [2];
    bit    all_diff;
    int    free;
    coin_t head;
    raw[0] = rn;
    raw[1] = rd;
    if (r) begin
      m_q.delete();
      m_ovf   = 0;
      m_n     = 0;
      m_d     = 0;
      m_block = 0;
      for (int l = 0; l < 2; l++) begin
        m_s1[l]  = 0;
        m_s2[l]  = 0;
        m_acc[l] = 0;
        for (int k = 0; k < DB; k++) m_hist[l][k] = 0;
      end
      return;
    end
    for (int l = 0; l < 2; l++) begin
      for (int k = DB - 1; k > 0; k--) m_hist[l][k] = m_hist[l][k-1];
      m_hist[l][0] = m_s2[l];
      all_diff = 1;
      for (int k = 0; k < DB; k++) if (m_hist[l][k] == m_acc[l]) all_diff = 0;
      ev[l] = 0;
      if (all_diff) begin
        m_acc[l] = ~m_acc[l];
        ev[l]    = m_acc[l];
      end
    end
    free = DEPTH - m_q.size();
    m_n  = 0;
    m_d  = 0;
    if (m_block == 0 && m_q.size() != 0 && !h) begin
      head    = m_q.pop_front();
      m_n     = (head == COIN_NICKEL);
      m_d     = (head == COIN_DIME);
      m_block = 2;
    end else if (m_block > 0) begin
      m_block--;
    end
    for (int l = 0; l < 2; l++) begin
      if (ev[l]) begin
        if (free > 0) begin
          m_q.push_back(l == 0 ? COIN_NICKEL : COIN_DIME);
          free--;
        end else begin
          m_ovf = 1;
        end
      end
    end
    for (int l = 0; l < 2; l++) begin
      m_s2[l] = m_s1[l];
      m_s1[l] = raw[l];
    end
  endfunction

  // One clock: advance the model with this cycle's inputs, then compare
  // the DUT outputs of the next cycle, sampled 1 time unit after the edge.
  task automatic tick();
    model_step(rst, nickel_raw, dime_raw, hold);
    @(posedge clk);
    #1;
    cyc++;
    check("model_N", N, m_n);
    check("model_D", D, m_d);
    check("model_pending", pending, m_q.size());
    check("model_overflow", overflow, m_ovf);
    check("N_D_exclusive", N && D, 0);
  endtask

  task automatic do_reset();
    rst = 1; nickel_raw = 0; dime_raw = 0; hold = 0;
    tick();
    check("reset_N", N, 0);
    check("reset_D", D, 0);
    check("reset_pending", pending, 0);
    check("reset_overflow", overflow, 0);
    rst = 0;
    cyc = 0;
  endtask

  typedef struct {
    bit nr;
    bit dr;
    bit hd;
    bit en;
    bit ed;
    int ep;
    bit eo;
  } vec_t;

  vec_t tv [14];

  initial begin
    int cnt_a, cnt_b, pmax, n_at, d_at, last;
    bit seen;
    int run_n, run_d, run_h;

    // Row i: inputs during cycle i, expected outputs during cycle i+1.
    for (int i = 0; i < 14; i++) begin
      tv[i].nr = (i < 10);
      tv[i].dr = 0;
      tv[i].hd = 0;
      tv[i].en = (i == 6);
      tv[i].ed = 0;
      tv[i].ep = (i == 5) ? 1 : 0;
      tv[i].eo = 0;
    end

    // 1: single nickel
    do_reset();
    for (int i = 0; i < 14; i++) begin
      nickel_raw = tv[i].nr; dime_raw = tv[i].dr; hold = tv[i].hd;
      tick();
      check("t1_N", N, tv[i].en);
      check("t1_D", D, tv[i].ed);
      check("t1_pending", pending, tv[i].ep);
      check("t1_overflow", overflow, tv[i].eo);
    end
    for (int i = 0; i < 6; i++) tick();

    // 2: glitch rejection, then a real dime
    do_reset();
    cnt_a = 0; pmax = 0;
    for (int i = 0; i < 16; i++) begin
      dime_raw = (i < 3);
      tick();
      if (D) cnt_a++;
      if (pending > pmax) pmax = pending;
    end
    check("t2_glitch_D", cnt_a, 0);
    check("t2_glitch_pending", pmax, 0);
    cnt_a = 0;
    for (int i = 0; i < 24; i++) begin
      dime_raw = (i < 6);
      tick();
      if (D) cnt_a++;
    end
    check("t2_dime_count", cnt_a, 1);

    // 3: simultaneous coins
    do_reset();
    n_at = -1; d_at = -1;
    for (int i = 0; i < 18; i++) begin
      nickel_raw = (i < 10); dime_raw = (i < 10);
      tick();
      if (N && n_at < 0) n_at = cyc;
      if (D && d_at < 0) d_at = cyc;
    end
    check("t3_N_cycle", n_at, 7);
    check("t3_D_cycle", d_at, 10);
    check("t3_overflow", overflow, 0);

    // 4: hold stall
    do_reset();
    cnt_a = 0;
    for (int c = 0; c <= 20; c++) begin
      dime_raw = (c < 6); hold = 1;
      tick();
      if (cyc == 5) check("t4_pending_c5", pending, 0);
      if (cyc == 6) check("t4_pending_c6", pending, 1);
      if (D) cnt_a++;
    end
    check("t4_pending_c21", pending, 1);
    check("t4_no_D_while_hold", cnt_a, 0);
    hold = 0;
    tick();
    check("t4_D_c22", D, 1);
    for (int i = 0; i < 4; i++) tick();

    // 5: overflow under hold, then drain
    do_reset();
    hold = 1; pmax = 0;
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 12; i++) begin
        nickel_raw = (i < 6);
        tick();
        if (pending > pmax) pmax = pending;
      end
      if (k == 3) check("t5_overflow_after4", overflow, 0);
    end
    check("t5_overflow_after5", overflow, 1);
    check("t5_pending_max", pmax, 4);
    hold = 0; cnt_a = 0; last = -1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (N) begin
        if (last >= 0) check("t5_spacing", cyc - last, 3);
        last = cyc;
        cnt_a++;
      end
    end
    check("t5_N_count", cnt_a, 4);

    // 6: reset with three coins queued and a pulse in flight
    hold = 1;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 12; i++) begin
        nickel_raw = (i < 6);
        tick();
      end
    end
    hold = 0; seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (N) seen = 1;
    end
    check("t6_pulse_seen", seen, 1);
    check("t6_pending_before", pending, 3);
    rst = 1;
    tick();
    rst = 0;
    check("t6_N", N, 0);
    check("t6_D", D, 0);
    check("t6_pending", pending, 0);
    check("t6_overflow", overflow, 0);
    cnt_b = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (N || D) cnt_b++;
    end
    check("t6_no_pulses", cnt_b, 0);

    // Randomized sensor runs, hold and occasional reset
    do_reset();
    run_n = 0; run_d = 0; run_h = 0;
    for (int i = 0; i < 1500; i++) begin
      if (run_n == 0) begin nickel_raw = $urandom_range(1, 0); run_n = $urandom_range(8, 1); end
      if (run_d == 0) begin dime_raw   = $urandom_range(1, 0); run_d = $urandom_range(8, 1); end
      if (run_h == 0) begin hold = ($urandom_range(3, 0) == 0); run_h = $urandom_range(12, 1); end
      run_n--; run_d--; run_h--;
      rst = ($urandom_range(299, 0) == 0);
      tick();
    end
    rst = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/coin_acceptor.md
# coin_acceptor

- Upstream input stage of the vending machine.
- Synchronises and debounces the raw nickel and dime slot sensors, queues accepted coins in a small FIFO, and replays them as single-cycle, mutually exclusive `N`/`D` pulses.
- Pulses are spaced so the downstream Moore FSM never receives a coin while it sits in its vend state.
- Supports a `hold` stall input.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable cycles required before a level change is accepted. Must be ≥1.
- `FIFO_DEPTH`, default 4: coin queue entries. Power of two, ≥2.
- `clk` in 1: single clock; everything is on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `nickel_raw` in 1: asynchronous nickel sensor level, high while a coin is in the slot.
- `dime_raw` in 1: asynchronous dime sensor level.
- `hold` in 1: when high, no new coin is popped. Normally tied to the downstream `open`.
- `N` out 1: one-cycle nickel pulse.
- `D` out 1: one-cycle dime pulse.
- `pending` out $clog2(FIFO_DEPTH+1): current FIFO occupancy.
- `overflow` out 1: sticky. Set when any accepted coin is dropped; cleared only by `rst`.

## Operation
**Reset**
- Reset values: `N`=0, `D`=0, `pending`=0, `overflow`=0.
- Sync flops, debounce state/counters, FIFO pointers and FSM return to IDLE, all zeroed.
- Reset mid-operation discards queued coins; no pulse is emitted in the cycle after reset.

**Synchronise**
- Two flops per line produce `s2`.

**Debounce (per line)**
- Registers: `stable` (reset 0) and `cnt`.
- If `s2`==`stable`: `cnt` clears to 0.
- Otherwise, if `cnt`==DEBOUNCE_CYCLES-1: `stable` toggles and `cnt` clears to 0.
- Otherwise: `cnt` increments.
- A 0→1 toggle of `stable` raises a coin event on that same edge. A 1→0 toggle raises no event.
- Pulses shorter than DEBOUNCE_CYCLES synced cycles are rejected.
- A line held high through reset is accepted as a coin after debounce.

**FIFO**
- Entry type is `coin_t`. Up to two writes per cycle.
- Simultaneous events are written nickel first, then dime.
- Free space is judged against occupancy at the start of the cycle; a concurrent pop gives no credit.
- If only one slot is free, the nickel is stored, the dime is dropped and `overflow` sets.
- If full, both events are dropped and `overflow` sets.
- Pointers wrap modulo FIFO_DEPTH.
- `pending` = writes − reads. A push and pop in the same cycle leave it unchanged (±net).

**Emit FSM (IDLE, PULSE, GAP)**
- IDLE: if `pending`≠0 and `hold`==0, pop the head into `coin_q` and go to PULSE. Else stay.
- PULSE: `N` = (`coin_q`==COIN_NICKEL), `D` = (`coin_q`==COIN_DIME). Go to GAP.
- GAP: outputs low. Go to IDLE.
- `N` and `D` are never high together.
- `hold` is sampled only in IDLE and has no effect in PULSE or GAP.

## Timing
- `nickel_raw` rises and meets setup before edge 1: `s2` is high in cycle 2, the event and enqueue occur on edge DEBOUNCE_CYCLES+2, and `N` is high in cycle DEBOUNCE_CYCLES+3 (cycle 7 at default) when idle with `hold` low.
- Minimum spacing between consecutive pulses is 3 cycles (PULSE, GAP, IDLE pop decision).
- This spacing guarantees the downstream FSM has left CENTS_15 before the next pulse.
- `hold` rising in IDLE blocks the pop in that cycle.
- Release latency: `hold` falls in cycle t, pulse appears in cycle t+1.
- `N`, `D`, `pending` and `overflow` are registered outputs.

## Structure
- Package `vending_pkg` holds:
  - `typedef enum logic {COIN_NICKEL, COIN_DIME} coin_t`
  - `typedef enum logic [1:0] {EMIT_IDLE, EMIT_PULSE, EMIT_GAP} emit_state_t`
- Sub-module `coin_debounce`: sync chain, debounce and rise-event output. Instantiated once per line, parameterised by DEBOUNCE_CYCLES.
- FIFO and emit FSM are inline in `coin_acceptor`.

## Test plan
1. **Single nickel, default params:** `nickel_raw` high 10 cycles from cycle 0 → `N` high only in cycle 7, `D` never, `pending` 1 during cycle 6 only.
2. **Glitch rejection:** `dime_raw` high 3 cycles → no `D`, `pending` stays 0. A later 6-cycle dime → exactly one `D`.
3. **Simultaneous coins:** both raws rise in cycle 0 → `N` in cycle 7, `D` in cycle 10, `overflow` 0.
4. **Hold stall:** `hold` high cycles 0–20 with one dime inserted → `pending`=1 from cycle 6, no `D`. `hold` falls in cycle 21 → `D` in cycle 22.
5. **Overflow:** `hold` high, 5 separate nickels → `pending` saturates at 4 and `overflow` sets on the 5th event. Releasing `hold` → exactly 4 `N` pulses, 3 cycles apart.
6. **Reset mid-operation:** `rst` one cycle with 3 coins queued and FSM in PULSE → next cycle `N`=`D`=0, `pending`=0, `overflow`=0. No pulses follow without new coins.
